lcd_frame_writer: RTL and testbench
===================================

# lcd_frame_writer

Parametrised LCD frame refresher: holds a ROWS×COLS character buffer and, on a start request, streams the whole frame to a character LCD (HD44780-style) controller through a busy-gated write strobe. It is the next-generation update engine under lcd_ber_top. It is generalised from a fixed single-line writer to arbitrary geometry, with queued start requests and an optional clear-display prologue.

## Interface
Parameters:
- COLS, 16, characters per row (1..40)
- ROWS, 2, number of rows (1..4)
- ADDR_W, 5, buffer address width; must satisfy 2^ADDR_W >= ROWS*COLS

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  frame update request, sampled every cycle
- buf_we  in  1  buffer write enable
- buf_addr  in  ADDR_W  linear buffer address = row*COLS + col
- buf_data  in  8  character code
- lcd_busy  in  1  downstream LCD controller busy
- lcd_we  out  1  one-cycle write strobe to LCD controller
- lcd_rs  out  1  0 = command byte, 1 = data byte
- lcd_data  out  8  byte to write
- active  out  1  frame transfer in progress
- done  out  1  one-cycle pulse at frame completion

## Operation
- Buffer: ROWS*COLS×8 register/RAM. Writes occur whenever buf_we=1, including during a transfer. Writes with buf_addr >= ROWS*COLS are ignored. The buffer is not cleared by RST.
- Frame sequence, per row r = 0..ROWS-1: one command 0x80|BASE(r), then COLS data bytes from buffer[r*COLS .. r*COLS+COLS-1].
- BASE table: r0 = 0x00, r1 = 0x40, r2 = COLS, r3 = 0x40+COLS.
- Transactions per frame: ROWS*(COLS+1), plus 1 with clear enabled.
- States:
  - IDLE: on start=1, go to CLR if enabled, else ROWCMD(row 0).
  - CLR, ROWCMD, CHAR: issue states. Each asserts lcd_we for one cycle only in a cycle where lcd_busy=0, then goes to WAIT with the return state recorded.
  - WAIT: the cycle after a strobe is unconditional. After that, leave when lcd_busy=0 and advance to the next issue state (CHAR col+1, ROWCMD row+1, or DONE).
  - DONE: one cycle. Asserts done. Returns to IDLE, or back to the first issue state if pending=1.
- Pending: start=1 in any state other than IDLE sets pending. DONE consumes pending and clears it. Multiple starts during one frame collapse into one re-run. start arriving exactly in the DONE cycle also counts as pending.
- Read/write collision: a character byte is read from the buffer in its issue cycle. A simultaneous buf_we to the same address issues the old value; the new value lands for the next frame.

## Timing
- Reset values: lcd_we=0, lcd_rs=0, lcd_data=0x00, active=0, done=0, pending=0, state=IDLE, row/col counters=0. RST takes effect immediately (asynchronous), including mid-frame. The aborted frame is not resumed.
- start is sampled at rising edge k in IDLE. active=1 from edge k. The earliest lcd_we is in cycle k+1 if lcd_busy=0.
- lcd_rs and lcd_data are valid in the lcd_we cycle and held until the next strobe.
- Minimum strobe spacing is 2 cycles when lcd_busy stays 0.
- lcd_busy held high stalls indefinitely with no strobe and no timeout.
- done is high for the single DONE cycle. active falls at the edge ending DONE unless a re-run starts, in which case active stays 1 continuously.

## Configuration
- LCD_CLEAR_EN defined: each frame begins with command 0x01 (rs=0) in state CLR, followed by the normal WAIT before row 0.
- LCD_CLEAR_EN undefined: the CLR state and its logic are absent. Frames begin at ROWCMD row 0.

## Test plan
- COLS=16, ROWS=2, buffer = "HELLO WORLD" padded with 0x20, lcd_busy=0, single start:
  - 34 strobes.
  - Strobe 1 = 0x80 rs=0; strobes 2..17 = "HELLO WORLD     " rs=1.
  - Strobe 18 = 0xC0 rs=0; strobes 19..34 = buffer[16..31].
  - One done pulse; active=0 afterwards.
- lcd_busy toggling every 6 cycles: every strobe occurs only with lcd_busy=0 and after its preceding WAIT. Byte order is identical to the first test.
- start pulsed 3 times during a frame: exactly one re-run (68 strobes total), two done pulses, active stays high between the frames.
- RST asserted after strobe 10:
  - lcd_we, active and done go to 0 asynchronously.
  - The next start produces 0x80 as its first byte.
  - The buffer contents are intact.
- buf_we to address 5 ('Q') in the same cycle that address 5 is issued: that frame sends the old byte, the next frame sends 'Q'. A write to address 40 (out of range) has no effect.
- With LCD_CLEAR_EN, COLS=20, ROWS=4: 85 strobes; first = 0x01; row commands = 0x80, 0xC0, 0x94, 0xD4.

Source files
------------

// File: rtl/lcd_frame_writer_if.sv
// Port bundle between lcd_frame_writer and its host / LCD controller.
// slave = frame writer side, master = host/testbench side.
interface lcd_frame_writer_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic              lcd_busy;
    logic              lcd_we;
    logic              lcd_rs;
    logic [7:0]        lcd_data;
    logic              active;
    logic              done;

    modport slave (
        input  start, buf_we, buf_addr, buf_data, lcd_busy,
        output lcd_we, lcd_rs, lcd_data, active, done
    );

    modport master (
        output start, buf_we, buf_addr, buf_data, lcd_busy,
        input  lcd_we, lcd_rs, lcd_data, active, done
    );
endinterface

// File: rtl/lcd_frame_writer.sv
// HD44780-style frame refresher: streams a ROWS x COLS character buffer to an LCD controller.
// Define LCD_CLEAR_EN to prefix every frame with the clear-display command (0x01).
module lcd_frame_writer #(
    parameter int COLS   = 16,
    parameter int ROWS   = 2,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    lcd_frame_writer_if.slave bus
);
    localparam int DEPTH = ROWS * COLS;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROWCMD,
        S_CHAR,
        S_WAIT,
        S_DONE
`ifdef LCD_CLEAR_EN
        , S_CLR
`endif
    } state_t;

`ifdef LCD_CLEAR_EN
    localparam state_t FIRST_ISSUE = S_CLR;
`else
    localparam state_t FIRST_ISSUE = S_ROWCMD;
`endif

    logic [7:0]        mem_q [2**ADDR_W];
    state_t            state_q;
    state_t            ret_q;
    logic [1:0]        row_q;
    logic [COL_W-1:0]  col_q;
    logic [ADDR_W-1:0] idx_q;
    logic              pending_q;
    logic              active_q;
    logic              done_q;
    logic              rs_q;
    logic [7:0]        data_q;

    logic              issuing;
    logic              issue_rs;
    logic [7:0]        issue_byte;
    logic              lcd_go;

    // Set-DDRAM-address command for the first cell of a row.
    function automatic logic [7:0] row_cmd(input logic [1:0] row);
        case (row)
            2'd0:    row_cmd = 8'h80;
            2'd1:    row_cmd = 8'hC0;
            2'd2:    row_cmd = 8'(8'h80 + COLS);
            default: row_cmd = 8'(8'hC0 + COLS);
        endcase
    endfunction

    // NOTE: the character buffer has no reset; contents survive RST, and leaving it out
    // of the reset net lets synthesis map it onto plain storage.
    always_ff @(posedge CLK) begin
        if (bus.buf_we && int'(bus.buf_addr) < DEPTH)
            mem_q[bus.buf_addr] <= bus.buf_data;
    end

    // NOTE: every output of an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        issuing    = 1'b0;
        issue_rs   = 1'b0;
        issue_byte = 8'h00;
        case (state_q)
`ifdef LCD_CLEAR_EN
            S_CLR: begin
                issuing    = 1'b1;
                issue_byte = 8'h01;
            end
`endif
            S_ROWCMD: begin
                issuing    = 1'b1;
                issue_byte = row_cmd(row_q);
            end
            S_CHAR: begin
                issuing    = 1'b1;
                issue_rs   = 1'b1;
                issue_byte = mem_q[idx_q];
            end
            default: ;
        endcase
    end

    // The strobe is gated by lcd_busy in the same cycle, so it never fires into a busy controller.
    assign lcd_go = issuing && !bus.lcd_busy;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ret_q     <= S_IDLE;
            row_q     <= 2'd0;
            col_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (bus.start && state_q != S_IDLE)
                pending_q <= 1'b1;
            if (lcd_go) begin
                rs_q   <= issue_rs;
                data_q <= issue_byte;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q  <= FIRST_ISSUE;
                        active_q <= 1'b1;
                    end
                end
`ifdef LCD_CLEAR_EN
                S_CLR: begin
                    if (lcd_go) begin
                        state_q <= S_WAIT;
                        ret_q   <= S_ROWCMD;
                    end
                end
`endif
                S_ROWCMD: begin
                    if (lcd_go) begin
                        state_q <= S_WAIT;
                        ret_q   <= S_CHAR;
                    end
                end
                S_CHAR: begin
                    if (lcd_go) begin
                        state_q <= S_WAIT;
                        idx_q   <= idx_q + 1'b1;
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_q <= '0;
                            if (row_q == 2'(ROWS - 1)) begin
                                ret_q <= S_DONE;
                            end else begin
                                ret_q <= S_ROWCMD;
                                row_q <= row_q + 2'd1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                            ret_q <= S_CHAR;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.lcd_busy) begin
                        state_q <= ret_q;
                        if (ret_q == S_DONE)
                            done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    row_q     <= 2'd0;
                    col_q     <= '0;
                    idx_q     <= '0;
                    pending_q <= 1'b0;
                    // A start seen in this very cycle counts as pending too.
                    if (pending_q || bus.start) begin
                        state_q <= FIRST_ISSUE;
                    end else begin
                        state_q  <= S_IDLE;
                        active_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.lcd_we   = lcd_go;
    assign bus.lcd_rs   = lcd_go ? issue_rs : rs_q;
    assign bus.lcd_data = lcd_go ? issue_byte : data_q;
    assign bus.active   = active_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_lcd_frame_writer.sv
// Self-checking bench for lcd_frame_writer: randomized buffer contents checked against a
// frame-level reference model of the expected command/data byte stream.
`timescale 1ns/1ps
module tb_lcd_frame_writer;
`ifdef LCD_CLEAR_EN
    localparam int COLS = 20, ROWS = 4, ADDR_W = 7, CLR = 1;
`else
    localparam int COLS = 16, ROWS = 2, ADDR_W = 6, CLR = 0;
`endif
    localparam int DEPTH     = ROWS * COLS;
    localparam int FRAME_LEN = ROWS * (COLS + 1) + CLR;
    localparam int BUDGET    = 4000;

    typedef logic [8:0] strobe_t;        // {rs, data}
    typedef strobe_t strobe_q_t[$];

    logic CLK = 1'b0;
    logic RST = 1'b1;

    lcd_frame_writer_if #(.ADDR_W(ADDR_W)) bus ();

    lcd_frame_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    logic [7:0] model_mem [DEPTH];
    int         n_pass = 0;
    int         n_total = 0;
    strobe_t    got_q[$];
    int         done_cnt = 0;
    int         busy_viol = 0;
    int         gap_viol = 0;
    int         cyc = 0;
    int         last_we = -10;

    // Monitor: records every strobe and done pulse, sampled on the falling edge.
    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            if (bus.lcd_we) begin
                got_q.push_back({bus.lcd_rs, bus.lcd_data});
                if (bus.lcd_busy !== 1'b0) busy_viol++;
                if (cyc - last_we < 2) gap_viol++;
                last_we = cyc;
            end
            if (bus.done) done_cnt++;
        end
    end

    // Reference frame: optional clear, then per row a DDRAM address command and the row's bytes.
    function automatic strobe_q_t build_frame();
        strobe_q_t q;
        int        base;
        if (CLR != 0) q.push_back({1'b0, 8'h01});
        for (int r = 0; r < ROWS; r++) begin
            base = ((r % 2) == 1 ? 'h40 : 0) + (r >= 2 ? COLS : 0);
            q.push_back({1'b0, 8'(128 + base)});
            for (int c = 0; c < COLS; c++)
                q.push_back({1'b1, model_mem[r * COLS + c]});
        end
        return q;
    endfunction

    function automatic int frame_diff(strobe_q_t e, strobe_q_t g);
        if (e.size() != g.size()) return -2;
        foreach (e[i]) if (e[i] !== g[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_buf(input int addr, input logic [7:0] d);
        bus.buf_we   = 1'b1;
        bus.buf_addr = ADDR_W'(addr);
        bus.buf_data = d;
        tick();
        bus.buf_we   = 1'b0;
        if (addr < DEPTH) model_mem[addr] = d;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            tick();
            if (done_cnt >= target) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        n_total++; if (bus.lcd_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", bus.lcd_we); else n_pass++;
        n_total++; if (bus.lcd_rs !== 1'b0) $display("FAIL reset_rs got=%b exp=0", bus.lcd_rs); else n_pass++;
        n_total++; if (bus.lcd_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", bus.lcd_data); else n_pass++;
        n_total++; if (bus.active !== 1'b0) $display("FAIL reset_active got=%b exp=0", bus.active); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else n_pass++;
        RST = 1'b0;
        repeat (2) tick();
        n_total++; if (bus.active !== 1'b0) $display("FAIL idle_active got=%b exp=0", bus.active); else n_pass++;
    endtask

    task automatic test_single_frame();
        string     msg = "HELLO WORLD";
        strobe_q_t exp;
        int        base;
        bit        to;
        for (int a = 0; a < DEPTH; a++)
            write_buf(a, (a < msg.len()) ? msg[a] : 8'h20);
        exp  = build_frame();
        got_q.delete();
        base = done_cnt;
        gap_viol = 0;
        pulse_start();
        n_total++; if (bus.active !== 1'b1) $display("FAIL start_active got=%b exp=1", bus.active); else n_pass++;
        wait_done(base + 1, to);
        repeat (3) tick();
        n_total++; if (to) $display("FAIL single_timeout got=%0d strobes exp done", got_q.size()); else n_pass++;
        n_total++; if (got_q.size() != FRAME_LEN) $display("FAIL single_count got=%0d exp=%0d", got_q.size(), FRAME_LEN); else n_pass++;
        n_total++;
        if (got_q.size() == 0 || got_q[0] !== exp[0]) $display("FAIL single_first got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : 9'h1FF, exp[0]);
        else n_pass++;
        n_total++; if (frame_diff(exp, got_q) != -1) $display("FAIL single_bytes first_bad=%0d exp=-1", frame_diff(exp, got_q)); else n_pass++;
        n_total++; if (done_cnt - base != 1) $display("FAIL single_done got=%0d exp=1", done_cnt - base); else n_pass++;
        n_total++; if (bus.active !== 1'b0) $display("FAIL single_active_after got=%b exp=0", bus.active); else n_pass++;
        n_total++; if (gap_viol != 0) $display("FAIL single_spacing got=%0d exp=0", gap_viol); else n_pass++;
    endtask

    task automatic test_busy_stall();
        strobe_q_t exp;
        int        base;
        bit        to;
        for (int a = 0; a < DEPTH; a++) write_buf(a, 8'($urandom_range(32, 126)));
        exp  = build_frame();
        got_q.delete();
        base = done_cnt;
        bus.lcd_busy = 1'b1;
        pulse_start();
        repeat (50) tick();
        n_total++; if (got_q.size() != 0) $display("FAIL stall_strobes got=%0d exp=0", got_q.size()); else n_pass++;
        n_total++; if (bus.active !== 1'b1) $display("FAIL stall_active got=%b exp=1", bus.active); else n_pass++;
        bus.lcd_busy = 1'b0;
        wait_done(base + 1, to);
        n_total++; if (to || frame_diff(exp, got_q) != -1) $display("FAIL stall_bytes first_bad=%0d timeout=%0b exp=-1", frame_diff(exp, got_q), to); else n_pass++;
    endtask

    task automatic test_busy_toggle();
        strobe_q_t exp;
        int        base;
        bit        to;
        for (int a = 0; a < DEPTH; a++) write_buf(a, 8'($urandom_range(32, 126)));
        exp  = build_frame();
        got_q.delete();
        base = done_cnt;
        busy_viol = 0;
        gap_viol  = 0;
        pulse_start();
        to = 1'b1;
        for (int i = 1; i < BUDGET; i++) begin
            tick();
            if (i % 6 == 0) bus.lcd_busy = ~bus.lcd_busy;
            if (done_cnt > base) begin
                to = 1'b0;
                break;
            end
        end
        bus.lcd_busy = 1'b0;
        repeat (2) tick();
        n_total++; if (to) $display("FAIL toggle_timeout got=%0d strobes exp done", got_q.size()); else n_pass++;
        n_total++; if (frame_diff(exp, got_q) != -1) $display("FAIL toggle_bytes first_bad=%0d exp=-1", frame_diff(exp, got_q)); else n_pass++;
        n_total++; if (busy_viol != 0) $display("FAIL toggle_busy_strobe got=%0d exp=0", busy_viol); else n_pass++;
        n_total++; if (gap_viol != 0) $display("FAIL toggle_spacing got=%0d exp=0", gap_viol); else n_pass++;
    endtask

    task automatic test_back_to_back();
        strobe_q_t exp;
        int        base;
        int        drops = 0;
        bit        to = 1'b1;
        exp  = build_frame();
        exp  = {exp, exp};
        got_q.delete();
        base = done_cnt;
        pulse_start();
        for (int i = 1; i < BUDGET; i++) begin
            bus.start = (i == 5 || i == 12 || i == 20);
            tick();
            if (done_cnt >= base + 2) begin
                to = 1'b0;
                break;
            end
            if (bus.active !== 1'b1) drops++;
        end
        bus.start = 1'b0;
        repeat (4) tick();
        n_total++; if (to) $display("FAIL b2b_timeout got=%0d done exp=2", done_cnt - base); else n_pass++;
        n_total++; if (done_cnt - base != 2) $display("FAIL b2b_done got=%0d exp=2", done_cnt - base); else n_pass++;
        n_total++; if (got_q.size() != 2 * FRAME_LEN) $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), 2 * FRAME_LEN); else n_pass++;
        n_total++; if (frame_diff(exp, got_q) != -1) $display("FAIL b2b_bytes first_bad=%0d exp=-1", frame_diff(exp, got_q)); else n_pass++;
        n_total++; if (drops != 0) $display("FAIL b2b_active_gap got=%0d exp=0", drops); else n_pass++;
        n_total++; if (bus.active !== 1'b0) $display("FAIL b2b_active_after got=%b exp=0", bus.active); else n_pass++;
    endtask

    task automatic test_start_in_done();
        int base;
        bit fired = 1'b0;
        bit to = 1'b1;
        got_q.delete();
        base = done_cnt;
        pulse_start();
        for (int i = 0; i < BUDGET; i++) begin
            if (bus.done === 1'b1 && !fired) begin
                bus.start = 1'b1;
                fired = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            if (done_cnt >= base + 2) begin
                to = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        repeat (4) tick();
        n_total++; if (to || done_cnt - base != 2) $display("FAIL done_cycle_start got=%0d done exp=2", done_cnt - base); else n_pass++;
        n_total++; if (got_q.size() != 2 * FRAME_LEN) $display("FAIL done_cycle_count got=%0d exp=%0d", got_q.size(), 2 * FRAME_LEN); else n_pass++;
    endtask

    task automatic test_reset_mid();
        strobe_q_t exp;
        int        base;
        bit        found = 1'b0;
        bit        to;
        exp = build_frame();
        got_q.delete();
        pulse_start();
        for (int i = 0; i < 500; i++) begin
            if (got_q.size() == 10 && bus.lcd_we === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_total++; if (!found) $display("FAIL midrst_reach got=%0d strobes exp=10", got_q.size()); else n_pass++;
        #1 RST = 1'b1;
        #1;
        n_total++; if (bus.lcd_we !== 1'b0) $display("FAIL midrst_we got=%b exp=0", bus.lcd_we); else n_pass++;
        n_total++; if (bus.active !== 1'b0) $display("FAIL midrst_active got=%b exp=0", bus.active); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL midrst_done got=%b exp=0", bus.done); else n_pass++;
        tick();
        RST = 1'b0;
        repeat (2) tick();
        got_q.delete();
        base = done_cnt;
        pulse_start();
        wait_done(base + 1, to);
        n_total++;
        if (got_q.size() == 0 || got_q[0] !== exp[0]) $display("FAIL midrst_first got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : 9'h1FF, exp[0]);
        else n_pass++;
        n_total++; if (to || frame_diff(exp, got_q) != -1) $display("FAIL midrst_buffer first_bad=%0d exp=-1", frame_diff(exp, got_q)); else n_pass++;
    endtask

    task automatic test_collision();
        localparam int POS = CLR + (5 / COLS) * (COLS + 1) + 1 + (5 % COLS);
        strobe_q_t exp;
        int        base;
        int        n = 0;
        bit        hit = 1'b0;
        bit        to;
        write_buf(5, 8'h41);
        exp = build_frame();
        got_q.delete();
        base = done_cnt;
        pulse_start();
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            #1;
            if (bus.lcd_we === 1'b1) begin
                if (n == POS) begin
                    bus.buf_we   = 1'b1;
                    bus.buf_addr = ADDR_W'(5);
                    bus.buf_data = 8'h51;
                    tick();
                    bus.buf_we   = 1'b0;
                    hit = 1'b1;
                    break;
                end
                n++;
            end
        end
        wait_done(base + 1, to);
        n_total++; if (!hit) $display("FAIL collide_reach got=%0d strobes exp=%0d", n, POS); else n_pass++;
        n_total++; if (to || frame_diff(exp, got_q) != -1) $display("FAIL collide_old first_bad=%0d exp=-1", frame_diff(exp, got_q)); else n_pass++;
        model_mem[5] = 8'h51;
        write_buf(DEPTH + 8, 8'h5A);
        exp = build_frame();
        got_q.delete();
        base = done_cnt;
        pulse_start();
        wait_done(base + 1, to);
        n_total++; if (to || frame_diff(exp, got_q) != -1) $display("FAIL collide_new first_bad=%0d exp=-1", frame_diff(exp, got_q)); else n_pass++;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.buf_we   = 1'b0;
        bus.buf_addr = '0;
        bus.buf_data = 8'h00;
        bus.lcd_busy = 1'b0;
        test_reset();
        test_single_frame();
        test_busy_stall();
        test_busy_toggle();
        test_back_to_back();
        test_start_in_done();
        test_reset_mid();
        test_collision();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
